// File: rtl/arm_pkg.sv
// Shared definitions for the arm balance, modulator and gate dead-time stages.
//   ch_state_t    : per-leg gate FSM state (OFF, DT, HI, LO), 2-bit encoding
//   *_DEF         : default dead time, minimum on-time and counter width
package arm_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_DT  = 2'd1,
    ST_HI  = 2'd2,
    ST_LO  = 2'd3
  } ch_state_t;

  localparam int unsigned DT_CYCLES_DEF = 50;   // 1 us @ 50 MHz
  localparam int unsigned MIN_ON_DEF    = 100;
  localparam int unsigned CNT_W_DEF     = 8;

endpackage

// File: rtl/arm_gate_deadtime_if.sv
// Signal bundle between the arm balance stage and the gate dead-time block.
//   fo         : firing word, 1 = upper switch on
//   enable     : converter running
//   fault_in   : external fault, asynchronous, active-high
//   fault_clr  : one-cycle pulse that clears the latched fault
//   gate_hi/lo : complementary gate pair per leg
//   fault_lat  : latched fault flag
//   busy       : leg is in dead time or inside its min-on window
// master drives the commands, slave is the dead-time block.
interface arm_gate_deadtime_if #(
  parameter int unsigned N_CH = 4
) ();
  logic [N_CH-1:0] fo;
  logic            enable;
  logic            fault_in;
  logic            fault_clr;
  logic [N_CH-1:0] gate_hi;
  logic [N_CH-1:0] gate_lo;
  logic            fault_lat;
  logic [N_CH-1:0] busy;

  modport master (
    output fo, enable, fault_in, fault_clr,
    input  gate_hi, gate_lo, fault_lat, busy
  );

  modport slave (
    input  fo, enable, fault_in, fault_clr,
    output gate_hi, gate_lo, fault_lat, busy
  );
endinterface

// File: rtl/arm_gate_deadtime_dt_channel.sv
// One leg of the gate driver: FSM, shared dead-time/min-on counter and the
// registered complementary gate pair.
//   clk, rst : clock, synchronous active-high reset
//   halt     : forces the leg to OFF with both gates low on the next edge
//   fo_q     : registered firing bit, 1 = upper switch
//   gate_hi  : upper gate, registered
//   gate_lo  : lower gate, registered
//   busy     : in dead time or inside the min-on window, registered
module dt_channel
  import arm_pkg::*;
#(
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
  parameter int unsigned MIN_ON    = MIN_ON_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic halt,
  input  logic fo_q,
  output logic gate_hi,
  output logic gate_lo,
  output logic busy
);

  localparam logic [CNT_W-1:0] DT_LOAD  = CNT_W'(DT_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Gates and busy are decoded into registers alongside the state, so each
  // output changes on the same edge as the state that implies it.
  always_ff @(posedge clk) begin
    if (rst || halt) begin
      state   <= ST_OFF;
      cnt     <= '0;
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state   <= ST_DT;
          cnt     <= DT_LOAD;
          gate_hi <= 1'b0;
          gate_lo <= 1'b0;
          busy    <= 1'b1;
        end
        ST_DT: begin
          // fo_q is only looked at on expiry; changes during DT do not restart it
          if (cnt <= CNT_ONE) begin
            state   <= fo_q ? ST_HI : ST_LO;
            cnt     <= MIN_LOAD;
            gate_hi <= fo_q;
            gate_lo <= ~fo_q;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
          busy <= 1'b1;
        end
        ST_HI, ST_LO: begin
          if ((fo_q != (state == ST_HI)) && (cnt == '0)) begin
            state   <= ST_DT;
            cnt     <= DT_LOAD;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
            busy    <= 1'b1;
          end else begin
            if (cnt != '0) cnt <= cnt - CNT_ONE;
            // counter is still non-zero after this edge only if it was above one
            busy <= (cnt > CNT_ONE);
          end
        end
        default: begin
          state   <= ST_OFF;
          cnt     <= '0;
          gate_hi <= 1'b0;
          gate_lo <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arm_gate_deadtime.sv
// Converts the arm balance firing word into dead-time protected complementary
// gate pairs, with a latched fault path and enable gating.
//   clk, rst : clock, synchronous active-high reset
//   bus      : arm_gate_deadtime_if slave (fo, enable, fault_in, fault_clr in;
//              gate_hi, gate_lo, fault_lat, busy out)
module arm_gate_deadtime
  import arm_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DT_CYCLES = DT_CYCLES_DEF,
  parameter int unsigned MIN_ON    = MIN_ON_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  arm_gate_deadtime_if.slave   bus
);

  logic [N_CH-1:0] fo_q;
  logic            flt_m;
  logic            flt_s;
  logic            fault_lat;
  logic            halt;
  logic [N_CH-1:0] gate_hi_w;
  logic [N_CH-1:0] gate_lo_w;
  logic [N_CH-1:0] busy_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      fo_q      <= '0;
      flt_m     <= 1'b0;
      flt_s     <= 1'b0;
      fault_lat <= 1'b0;
    end else begin
      fo_q  <= bus.fo;
      flt_m <= bus.fault_in;
      flt_s <= flt_m;
      // an active synchronized fault wins over a simultaneous clear
      if (flt_s)              fault_lat <= 1'b1;
      else if (bus.fault_clr) fault_lat <= 1'b0;
    end
  end

  always_comb begin
    halt = flt_s | fault_lat | ~bus.enable;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    dt_channel #(
      .DT_CYCLES (DT_CYCLES),
      .MIN_ON    (MIN_ON),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .halt    (halt),
      .fo_q    (fo_q[i]),
      .gate_hi (gate_hi_w[i]),
      .gate_lo (gate_lo_w[i]),
      .busy    (busy_w[i])
    );
  end

  assign bus.gate_hi   = gate_hi_w;
  assign bus.gate_lo   = gate_lo_w;
  assign bus.busy      = busy_w;
  assign bus.fault_lat = fault_lat;

endmodule

// File: tb/tb_arm_gate_deadtime.sv
// Bench for arm_gate_deadtime with DT_CYCLES=4, MIN_ON=6: a per-cycle vector
// table with hand-derived expected outputs fed through a scoreboard queue,
// followed by a random phase checking overlap, dead time and min on-time.
module tb_arm_gate_deadtime;

  localparam int unsigned N_CH = 4;
  localparam int unsigned DT   = 4;
  localparam int unsigned MON  = 6;

  typedef struct {
    logic        rst;
    logic        en;
    logic        fin;
    logic        fclr;
    logic [3:0]  fo;
    int unsigned n;
    logic [3:0]  hi;
    logic [3:0]  lo;
    logic [3:0]  busy;
    logic        flt;
  } vec_t;

  typedef struct packed {
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] busy;
    logic       flt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  arm_gate_deadtime_if #(.N_CH(N_CH)) bus ();

  arm_gate_deadtime #(
    .N_CH      (N_CH),
    .DT_CYCLES (DT),
    .MIN_ON    (MON),
    .CNT_W     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t        tbl[$];
  exp_t        sb[$];
  exp_t        want;
  exp_t        got;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  logic [3:0]  prev_hi;
  logic [3:0]  prev_lo;
  int unsigned low_run[4];
  int unsigned on_run[4];
  int unsigned cause_age;
  logic        cur_hi;
  logic        cur_lo;

  task automatic add(input logic r, input logic e, input logic fi, input logic fc,
                     input logic [3:0] f, input int unsigned n,
                     input logic [3:0] h, input logic [3:0] l,
                     input logic [3:0] b, input logic fl);
    vec_t v;
    v.rst = r; v.en = e; v.fin = fi; v.fclr = fc; v.fo = f; v.n = n;
    v.hi = h; v.lo = l; v.busy = b; v.flt = fl;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    bus.fo = 4'b0000;
    bus.enable = 1'b0;
    bus.fault_in = 1'b0;
    bus.fault_clr = 1'b0;

    // reset
    add(1'b1,1'b0,1'b0,1'b0,4'b0000,2, 4'b0000,4'b0000,4'b0000,1'b0);
    // start-up: 4 dead-time cycles then gates follow 1010
    add(1'b0,1'b1,1'b0,1'b0,4'b1010,4, 4'b0000,4'b0000,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1010,6, 4'b1010,4'b0101,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1010,1, 4'b1010,4'b0101,4'b0000,1'b0);
    // swap 1010 -> 0101
    add(1'b0,1'b1,1'b0,1'b0,4'b0101,1, 4'b1010,4'b0101,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b0101,4, 4'b0000,4'b0000,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b0101,1, 4'b0101,4'b1010,4'b1111,1'b0);
    // min-on: bit1 glitches and returns, bit3 change held until window ends
    add(1'b0,1'b1,1'b0,1'b0,4'b1111,1, 4'b0101,4'b1010,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,4, 4'b0101,4'b1010,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b0101,4'b1010,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,4, 4'b0101,4'b0010,4'b1000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,6, 4'b1101,4'b0010,4'b1000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b0000,1'b0);
    // bit2 drops for one cycle: DT runs full length, gate follows fo_q at expiry
    add(1'b0,1'b1,1'b0,1'b0,4'b1001,1, 4'b1101,4'b0010,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,4, 4'b1001,4'b0010,4'b0100,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,6, 4'b1101,4'b0010,4'b0100,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b0000,1'b0);
    // one-cycle fault: gates off on the third edge, latch sets
    add(1'b0,1'b1,1'b1,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b0000,4'b0000,4'b0000,1'b1);
    // clear while synchronized fault active is ignored; later clear works
    add(1'b0,1'b1,1'b1,1'b0,4'b1101,2, 4'b0000,4'b0000,4'b0000,1'b1);
    add(1'b0,1'b1,1'b1,1'b1,4'b1101,1, 4'b0000,4'b0000,4'b0000,1'b1);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,2, 4'b0000,4'b0000,4'b0000,1'b1);
    add(1'b0,1'b1,1'b0,1'b1,4'b1101,1, 4'b0000,4'b0000,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,4, 4'b0000,4'b0000,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b1111,1'b0);
    // enable drop and restart
    add(1'b0,1'b0,1'b0,1'b0,4'b1101,1, 4'b0000,4'b0000,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,4, 4'b0000,4'b0000,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b1111,1'b0);
    // fault inside the min-on window, then rst clears the latch
    add(1'b0,1'b1,1'b1,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b0000,4'b0000,4'b0000,1'b1);
    add(1'b1,1'b1,1'b0,1'b0,4'b1101,1, 4'b0000,4'b0000,4'b0000,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,4, 4'b0000,4'b0000,4'b1111,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,4'b1101,1, 4'b1101,4'b0010,4'b1111,1'b0);

    for (int r = 0; r < tbl.size(); r++) begin
      for (int unsigned k = 0; k < tbl[r].n; k++) begin
        rst           = tbl[r].rst;
        bus.enable    = tbl[r].en;
        bus.fault_in  = tbl[r].fin;
        bus.fault_clr = tbl[r].fclr;
        bus.fo        = tbl[r].fo;
        sb.push_back('{hi: tbl[r].hi, lo: tbl[r].lo, busy: tbl[r].busy, flt: tbl[r].flt});
        @(posedge clk);
        #1;
        cyc++;
        want = sb.pop_front();
        got  = '{hi: bus.gate_hi, lo: bus.gate_lo, busy: bus.busy, flt: bus.fault_lat};
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL tbl row %0d cyc %0d: got hi=%b lo=%b busy=%b flt=%b, want hi=%b lo=%b busy=%b flt=%b",
                   r, cyc, got.hi, got.lo, got.busy, got.flt, want.hi, want.lo, want.busy, want.flt);
        end
      end
    end

    // random phase: property checks on every leg
    bus.fault_clr = 1'b0;
    prev_hi = bus.gate_hi;
    prev_lo = bus.gate_lo;
    for (int i = 0; i < 4; i++) begin
      low_run[i] = 0;
      on_run[i]  = 100;
    end
    cause_age = 0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.fo = 4'($urandom_range(0, 15));
      bus.enable    = ($urandom_range(0, 299) != 0);
      bus.fault_in  = ($urandom_range(0, 399) == 0);
      bus.fault_clr = ($urandom_range(0, 9) == 0);
      if (!bus.enable || bus.fault_in || bus.fault_lat) cause_age = 0;
      else if (cause_age < 1000) cause_age++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        cur_hi = bus.gate_hi[i];
        cur_lo = bus.gate_lo[i];
        n_vec++;
        if (cur_hi && cur_lo) begin
          n_err++;
          $display("FAIL overlap ch%0d rnd %0d: got hi=1 lo=1, want not both", i, c);
        end
        if ((cur_hi && !prev_hi[i]) || (cur_lo && !prev_lo[i])) begin
          n_vec++;
          if (low_run[i] < DT) begin
            n_err++;
            $display("FAIL deadtime ch%0d rnd %0d: got %0d both-low cycles, want >= %0d",
                     i, c, low_run[i], DT);
          end
          on_run[i]  = 1;
          low_run[i] = 0;
        end else if (!cur_hi && !cur_lo) begin
          if (prev_hi[i] || prev_lo[i]) begin
            n_vec++;
            if (on_run[i] < MON && cause_age > 3) begin
              n_err++;
              $display("FAIL min_on ch%0d rnd %0d: got on-pulse %0d cycles, want >= %0d",
                       i, c, on_run[i], MON);
            end
          end
          low_run[i]++;
          on_run[i] = 0;
        end else begin
          on_run[i]++;
        end
        prev_hi[i] = cur_hi;
        prev_lo[i] = cur_lo;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
